// File: rtl/rv32i_multicycle_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_multicycle_ctrl_pkg
// Shared definitions for the rv32i multicycle sequencer and its neighbours
// (core, CSR block). Holds the stage encoding, common widths and a helper
// that maps a raw 3-bit stage value onto a legal stage.
// ---------------------------------------------------------------------------
package rv32i_multicycle_ctrl_pkg;

    localparam int STAGE_W = 3;
    localparam int INST_W  = 32;

    // Stage encoding is visible on stage_q, so the numeric values are fixed.
    typedef enum logic [STAGE_W-1:0] {
        ST_FETCH        = 3'd0,
        ST_DECODE       = 3'd1,
        ST_EXECUTE      = 3'd2,
        ST_MEMORYACCESS = 3'd3,
        ST_WRITEBACK    = 3'd4
    } stage_e;

    // Unused encodings (5..7) are treated as FETCH so a corrupted stage
    // register recovers by refetching instead of locking up.
    function automatic stage_e stage_decode(input logic [STAGE_W-1:0] raw);
        stage_e st;
        case (raw)
            3'd1:    st = ST_DECODE;
            3'd2:    st = ST_EXECUTE;
            3'd3:    st = ST_MEMORYACCESS;
            3'd4:    st = ST_WRITEBACK;
            default: st = ST_FETCH;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/rv32i_instret_counter.sv
// ---------------------------------------------------------------------------
// rv32i_instret_counter
// Retired-instruction counter. Increments by one on every cycle where en is
// high and wraps from all-ones back to zero.
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset, clears the count
//   en       in   count enable (one pulse per retired instruction)
//   count_q  out  current count, CNT_W bits
// ---------------------------------------------------------------------------
module rv32i_instret_counter #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] count_q
);

    logic [CNT_W-1:0] count_d;

    // Natural modulo-2^CNT_W wrap; no saturation.
    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/rv32i_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// rv32i_multicycle_ctrl
// Multicycle sequencer for the rv32i core: FETCH -> DECODE -> EXECUTE ->
// [MEMORYACCESS] -> WRITEBACK -> FETCH, with variable-latency imem/dmem
// handshakes, hazard stall, trap flush and a retired-instruction counter.
//
// Handshakes: i_req is high for every FETCH cycle; the fetch completes on the
// first cycle where i_req and i_ack are both high. d_req is high for every
// MEMORYACCESS cycle of a load/store; the access completes on the first cycle
// where d_req and d_ack are both high. An ack with its req low is ignored.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   inst                            instruction word from imem (valid with i_ack)
//   pc, rs1, rs2, imm               operand sources (XLEN)
//   opcode_*                        decoded instruction type
//   i_ack, d_ack                    imem / dmem responses
//   stall                           hold in DECODE or EXECUTE
//   flush                           abandon the current instruction, refetch
//   i_req, d_req                    imem / dmem requests
//   inst_q                          registered instruction
//   stage_q                         current stage encoding
//   a, b                            ALU operands (zero outside EXECUTE)
//   alu_stage .. csr_stage          stage decodes
//   done_tick                       one pulse per retired instruction
//   instret                         retired-instruction count (CNT_W, wraps)
// ---------------------------------------------------------------------------
module rv32i_multicycle_ctrl
    import rv32i_multicycle_ctrl_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int SKIP_MEM = 1,
    parameter int CNT_W    = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [INST_W-1:0]   inst,
    input  logic [XLEN-1:0]     pc,
    input  logic [XLEN-1:0]     rs1,
    input  logic [XLEN-1:0]     rs2,
    input  logic [XLEN-1:0]     imm,
    input  logic                opcode_jal,
    input  logic                opcode_auipc,
    input  logic                opcode_rtype,
    input  logic                opcode_branch,
    input  logic                opcode_load,
    input  logic                opcode_store,
    input  logic                i_ack,
    input  logic                d_ack,
    input  logic                stall,
    input  logic                flush,
    output logic                i_req,
    output logic                d_req,
    output logic [INST_W-1:0]   inst_q,
    output logic [STAGE_W-1:0]  stage_q,
    output logic [XLEN-1:0]     a,
    output logic [XLEN-1:0]     b,
    output logic                alu_stage,
    output logic                memoryaccess_stage,
    output logic                writeback_stage,
    output logic                csr_stage,
    output logic                done_tick,
    output logic [CNT_W-1:0]    instret
);

    localparam bit ALWAYS_MEM = (SKIP_MEM == 0);

    stage_e             stage_cur;
    stage_e             stage_d;
    logic [INST_W-1:0]  inst_d;
    logic               is_mem;

    assign stage_cur = stage_decode(stage_q);
    assign is_mem    = opcode_load | opcode_store;

    // Next-state / next-instruction logic.
    always_comb begin
        stage_d = ST_FETCH;
        inst_d  = inst_q;
        case (stage_cur)
            ST_FETCH: begin
                if (i_ack) begin
                    stage_d = ST_DECODE;
                    inst_d  = inst;
                end else begin
                    stage_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                stage_d = stall ? ST_DECODE : ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (stall) begin
                    stage_d = ST_EXECUTE;
                end else if (is_mem || ALWAYS_MEM) begin
                    stage_d = ST_MEMORYACCESS;
                end else begin
                    stage_d = ST_WRITEBACK;
                end
            end
            ST_MEMORYACCESS: begin
                // Non-memory ops only get here when the skip is disabled;
                // they pass through in one cycle and never look at d_ack.
                if (is_mem && !d_ack) begin
                    stage_d = ST_MEMORYACCESS;
                end else begin
                    stage_d = ST_WRITEBACK;
                end
            end
            ST_WRITEBACK: begin
                stage_d = ST_FETCH;
            end
            default: begin
                stage_d = ST_FETCH;
            end
        endcase
        // Flush beats every handshake: restart fetch and keep the old
        // instruction even if an i_ack landed in the same cycle.
        if (flush) begin
            stage_d = ST_FETCH;
            inst_d  = inst_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= ST_FETCH;
            inst_q  <= '0;
        end else begin
            stage_q <= stage_d;
            inst_q  <= inst_d;
        end
    end

    // Stage decodes and handshake requests follow stage_q directly.
    assign i_req              = (stage_cur == ST_FETCH);
    assign alu_stage          = (stage_cur == ST_EXECUTE);
    assign memoryaccess_stage = (stage_cur == ST_MEMORYACCESS);
    assign writeback_stage    = (stage_cur == ST_WRITEBACK);
    assign csr_stage          = memoryaccess_stage;
    assign d_req              = memoryaccess_stage & is_mem;
    assign done_tick          = writeback_stage & ~flush;

    // Operands are only driven in EXECUTE so downstream logic sees zeros
    // (and does not toggle) in every other stage.
    assign a = alu_stage ? ((opcode_jal | opcode_auipc) ? pc : rs1) : '0;
    assign b = alu_stage ? ((opcode_rtype | opcode_branch) ? rs2 : imm) : '0;

    rv32i_instret_counter #(
        .CNT_W (CNT_W)
    ) u_instret (
        .clk     (clk),
        .rst     (rst),
        .en      (done_tick),
        .count_q (instret)
    );

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Directed bench for rv32i_multicycle_ctrl. dut0 skips MEMORYACCESS and has
// a 4-bit instret so the wrap is reachable; dut1 always visits MEMORYACCESS.
// Inputs are driven on the falling edge; outputs are sampled 1 ns later,
// i.e. mid-cycle, reflecting the state registered at the previous rising edge.
module tb_rv32i_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst = '0;
  logic [31:0] pc = '0, rs1 = '0, rs2 = '0, imm = '0;
  logic        op_jal = 0, op_auipc = 0, op_rtype = 0, op_branch = 0, op_load = 0, op_store = 0;
  logic        i_ack = 0, d_ack = 0, stall = 0, flush = 0;

  logic        i_req0, d_req0, alu0, mem0, wb0, csr0, done0;
  logic [31:0] inst_q0, a0, b0;
  logic [2:0]  stage_q0;
  logic [3:0]  instret0;

  logic        i_req1, d_req1, alu1, mem1, wb1, csr1, done1;
  logic [31:0] inst_q1, a1, b1;
  logic [2:0]  stage_q1;
  logic [63:0] instret1;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_instret0 = '0;

  always #5 clk = ~clk;

  rv32i_multicycle_ctrl #(.XLEN(32), .SKIP_MEM(1), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .inst(inst), .pc(pc), .rs1(rs1), .rs2(rs2), .imm(imm),
    .opcode_jal(op_jal), .opcode_auipc(op_auipc), .opcode_rtype(op_rtype),
    .opcode_branch(op_branch), .opcode_load(op_load), .opcode_store(op_store),
    .i_ack(i_ack), .d_ack(d_ack), .stall(stall), .flush(flush),
    .i_req(i_req0), .d_req(d_req0), .inst_q(inst_q0), .stage_q(stage_q0),
    .a(a0), .b(b0), .alu_stage(alu0), .memoryaccess_stage(mem0),
    .writeback_stage(wb0), .csr_stage(csr0), .done_tick(done0), .instret(instret0)
  );

  rv32i_multicycle_ctrl #(.XLEN(32), .SKIP_MEM(0), .CNT_W(64)) dut1 (
    .clk(clk), .rst(rst), .inst(inst), .pc(pc), .rs1(rs1), .rs2(rs2), .imm(imm),
    .opcode_jal(op_jal), .opcode_auipc(op_auipc), .opcode_rtype(op_rtype),
    .opcode_branch(op_branch), .opcode_load(op_load), .opcode_store(op_store),
    .i_ack(i_ack), .d_ack(d_ack), .stall(stall), .flush(flush),
    .i_req(i_req1), .d_req(d_req1), .inst_q(inst_q1), .stage_q(stage_q1),
    .a(a1), .b(b1), .alu_stage(alu1), .memoryaccess_stage(mem1),
    .writeback_stage(wb1), .csr_stage(csr1), .done_tick(done1), .instret(instret1)
  );

  task automatic set_op(input logic jal, auipc, rtype, branch, load, store);
    op_jal = jal; op_auipc = auipc; op_rtype = rtype;
    op_branch = branch; op_load = load; op_store = store;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; i_ack = 0; d_ack = 0; stall = 0; flush = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs one instruction through dut0 from FETCH, acking fetch immediately.
  task automatic run_instr();
    bit seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      i_ack = (stage_q0 == 3'd0);
      #1;
      if (done0) seen = 1;
    end
    i_ack = 0;
    checks++;
    if (!seen) begin errors++; $display("FAIL run_instr_timeout got no done_tick exp done_tick within 10 cycles"); end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; i_ack = 1; flush = 1; stall = 1; inst = 32'hdeadbeef; set_op(1, 0, 1, 0, 1, 0);
    @(negedge clk);
    #1;
    checks++; if (stage_q0 !== 3'd0) begin errors++; $display("FAIL reset_stage got %0d exp 0", stage_q0); end
    checks++; if (inst_q0 !== 32'h0) begin errors++; $display("FAIL reset_inst_q got %08h exp 00000000", inst_q0); end
    checks++; if (instret0 !== 4'd0) begin errors++; $display("FAIL reset_instret got %0d exp 0", instret0); end
    checks++; if (instret1 !== 64'd0) begin errors++; $display("FAIL reset_instret1 got %0d exp 0", instret1); end
    rst = 1'b0; i_ack = 0; flush = 0; stall = 0; set_op(0, 0, 0, 0, 0, 0);
    #1;
    checks++; if (i_req0 !== 1'b1) begin errors++; $display("FAIL reset_i_req got %b exp 1", i_req0); end
    checks++; if ({d_req0, done0} !== 2'b00) begin errors++; $display("FAIL reset_d_req_done got %b exp 00", {d_req0, done0}); end
    checks++; if ({a0, b0} !== 64'h0) begin errors++; $display("FAIL reset_ab got %h exp 0", {a0, b0}); end
    exp_instret0 = 4'd0;
  endtask

  // ADD with same-cycle i_ack: stages 0,1,2,4,0.
  task automatic test_add();
    set_op(0, 0, 1, 0, 0, 0);
    rs1 = 32'h11; rs2 = 32'h22; imm = 32'h33; pc = 32'h44; inst = 32'h002081b3;
    @(negedge clk); i_ack = 1; #1;
    checks++; if (stage_q0 !== 3'd0 || i_req0 !== 1'b1) begin errors++; $display("FAIL add_fetch got stage %0d i_req %b exp stage 0 i_req 1", stage_q0, i_req0); end
    @(negedge clk); i_ack = 0; #1;
    checks++; if (stage_q0 !== 3'd1) begin errors++; $display("FAIL add_decode got %0d exp 1", stage_q0); end
    checks++; if (inst_q0 !== 32'h002081b3) begin errors++; $display("FAIL add_inst_q got %08h exp 002081b3", inst_q0); end
    @(negedge clk); #1;
    checks++; if (stage_q0 !== 3'd2 || alu0 !== 1'b1) begin errors++; $display("FAIL add_execute got stage %0d alu %b exp 2 1", stage_q0, alu0); end
    checks++; if (a0 !== 32'h11 || b0 !== 32'h22) begin errors++; $display("FAIL add_ab got %h %h exp 11 22", a0, b0); end
    @(negedge clk); #1;
    checks++; if (stage_q0 !== 3'd4 || wb0 !== 1'b1 || done0 !== 1'b1) begin errors++; $display("FAIL add_wb got stage %0d wb %b done %b exp 4 1 1", stage_q0, wb0, done0); end
    checks++; if (a0 !== 32'h0 || instret0 !== 4'd0) begin errors++; $display("FAIL add_wb_a_instret got a %h instret %0d exp 0 0", a0, instret0); end
    exp_instret0 = exp_instret0 + 4'd1;
    @(negedge clk); #1;
    checks++; if (stage_q0 !== 3'd0 || done0 !== 1'b0) begin errors++; $display("FAIL add_back_fetch got stage %0d done %b exp 0 0", stage_q0, done0); end
    checks++; if (instret0 !== exp_instret0) begin errors++; $display("FAIL add_instret got %0d exp %0d", instret0, exp_instret0); end
  endtask

  // LW: 4 FETCH + 1 DECODE + 1 EXECUTE + 3 MEMORYACCESS + 1 WRITEBACK = 10 cycles.
  task automatic test_lw();
    int fetch_cnt = 0, mem_cnt = 0, total = 0;
    bit done = 0;
    logic [31:0] a_seen = '0, b_seen = '0;
    set_op(0, 0, 0, 0, 1, 0);
    rs1 = 32'h1000; rs2 = 32'h5555; imm = 32'h4; pc = 32'h200; inst = 32'h0040a103;
    for (int c = 0; c < 30 && !done; c++) begin
      @(negedge clk);
      i_ack = (stage_q0 == 3'd0) && (fetch_cnt == 3);
      d_ack = (stage_q0 == 3'd3) && (mem_cnt == 2);
      #1;
      total++;
      if (i_req0) fetch_cnt++;
      if (d_req0) mem_cnt++;
      if (alu0) begin a_seen = a0; b_seen = b0; end
      if (done0) done = 1;
    end
    i_ack = 0; d_ack = 0;
    checks++; if (!done) begin errors++; $display("FAIL lw_timeout got no done_tick exp done_tick"); end
    checks++; if (fetch_cnt != 4) begin errors++; $display("FAIL lw_i_req_cycles got %0d exp 4", fetch_cnt); end
    checks++; if (mem_cnt != 3) begin errors++; $display("FAIL lw_d_req_cycles got %0d exp 3", mem_cnt); end
    checks++; if (total != 10) begin errors++; $display("FAIL lw_total_cycles got %0d exp 10", total); end
    checks++; if (a_seen !== 32'h1000 || b_seen !== 32'h4) begin errors++; $display("FAIL lw_ab got %h %h exp 1000 4", a_seen, b_seen); end
    exp_instret0 = exp_instret0 + 4'd1;
    @(negedge clk); #1;
    checks++; if (instret0 !== exp_instret0) begin errors++; $display("FAIL lw_instret got %0d exp %0d", instret0, exp_instret0); end
  endtask

  // JAL with 2 stall cycles in EXECUTE; stray i_ack in DECODE must be ignored.
  task automatic test_jal_stall();
    set_op(1, 0, 0, 0, 0, 0);
    pc = 32'h100; imm = 32'h20; rs1 = 32'hdead; rs2 = 32'hbeef; inst = 32'h0200006f;
    @(negedge clk); i_ack = 1; #1;
    @(negedge clk); i_ack = 1; inst = 32'hffffffff; #1;
    checks++; if (stage_q0 !== 3'd1) begin errors++; $display("FAIL jal_decode got %0d exp 1", stage_q0); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); i_ack = 0; stall = (k < 2); #1;
      checks++; if (stage_q0 !== 3'd2) begin errors++; $display("FAIL jal_exec_stage cycle %0d got %0d exp 2", k, stage_q0); end
      checks++; if (a0 !== 32'h100 || b0 !== 32'h20) begin errors++; $display("FAIL jal_exec_ab cycle %0d got %h %h exp 100 20", k, a0, b0); end
    end
    checks++; if (inst_q0 !== 32'h0200006f) begin errors++; $display("FAIL jal_inst_q got %08h exp 0200006f", inst_q0); end
    @(negedge clk); stall = 0; #1;
    checks++; if (stage_q0 !== 3'd4 || done0 !== 1'b1 || a0 !== 32'h0) begin errors++; $display("FAIL jal_wb got stage %0d done %b a %h exp 4 1 0", stage_q0, done0, a0); end
    exp_instret0 = exp_instret0 + 4'd1;
    @(negedge clk); #1;
    checks++; if (stage_q0 !== 3'd0 || instret0 !== exp_instret0) begin errors++; $display("FAIL jal_end got stage %0d instret %0d exp 0 %0d", stage_q0, instret0, exp_instret0); end
  endtask

  // Flush in MEMORYACCESS (with d_ack), in FETCH (with i_ack), in WRITEBACK.
  task automatic test_flush();
    set_op(0, 0, 0, 0, 0, 1);
    rs1 = 32'h300; imm = 32'h8; inst = 32'h0020a423;
    @(negedge clk); i_ack = 1; #1;
    @(negedge clk); i_ack = 0; #1;
    @(negedge clk); #1;
    @(negedge clk); d_ack = 1; flush = 1; #1;
    checks++; if (stage_q0 !== 3'd3 || d_req0 !== 1'b1) begin errors++; $display("FAIL flush_mem_pre got stage %0d d_req %b exp 3 1", stage_q0, d_req0); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL flush_mem_done got %b exp 0", done0); end
    @(negedge clk); d_ack = 0; i_ack = 1; inst = 32'h00000055; #1;
    checks++; if (stage_q0 !== 3'd0 || i_req0 !== 1'b1 || d_req0 !== 1'b0) begin errors++; $display("FAIL flush_mem_next got stage %0d i_req %b d_req %b exp 0 1 0", stage_q0, i_req0, d_req0); end
    checks++; if (instret0 !== exp_instret0) begin errors++; $display("FAIL flush_mem_instret got %0d exp %0d", instret0, exp_instret0); end
    @(negedge clk); i_ack = 0; flush = 0; #1;
    checks++; if (stage_q0 !== 3'd0 || inst_q0 !== 32'h0020a423) begin errors++; $display("FAIL flush_fetch got stage %0d inst_q %08h exp 0 0020a423", stage_q0, inst_q0); end
    set_op(0, 0, 1, 0, 0, 0);
    @(negedge clk); i_ack = 1; #1;
    @(negedge clk); i_ack = 0; #1;
    @(negedge clk); #1;
    @(negedge clk); flush = 1; #1;
    checks++; if (wb0 !== 1'b1 || done0 !== 1'b0) begin errors++; $display("FAIL flush_wb got wb %b done %b exp 1 0", wb0, done0); end
    @(negedge clk); flush = 0; #1;
    checks++; if (stage_q0 !== 3'd0 || instret0 !== exp_instret0) begin errors++; $display("FAIL flush_wb_next got stage %0d instret %0d exp 0 %0d", stage_q0, instret0, exp_instret0); end
  endtask

  // 4-bit instret wraps after 16 retirements; reset mid-EXECUTE.
  task automatic test_wrap_and_reset();
    do_reset();
    set_op(0, 0, 1, 0, 0, 0);
    for (int n = 0; n < 15; n++) run_instr();
    @(negedge clk); #1;
    checks++; if (instret0 !== 4'd15) begin errors++; $display("FAIL wrap_pre got %0d exp 15", instret0); end
    run_instr();
    @(negedge clk); #1;
    checks++; if (instret0 !== 4'd0) begin errors++; $display("FAIL wrap got %0d exp 0", instret0); end
    run_instr();
    @(negedge clk); inst = 32'h00000abc; i_ack = 1; #1;
    @(negedge clk); i_ack = 0; #1;
    @(negedge clk); #1;
    checks++; if (stage_q0 !== 3'd2 || inst_q0 !== 32'h00000abc || instret0 !== 4'd1) begin errors++; $display("FAIL rst_mid_pre got stage %0d inst_q %h instret %0d exp 2 abc 1", stage_q0, inst_q0, instret0); end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (stage_q0 !== 3'd0 || inst_q0 !== 32'h0 || instret0 !== 4'd0) begin errors++; $display("FAIL rst_mid got stage %0d inst_q %h instret %0d exp 0 0 0", stage_q0, inst_q0, instret0); end
    exp_instret0 = 4'd0;
  endtask

  // SKIP_MEM=0 ADD: 0,1,2,3,4 -> 5 cycles, one MEMORYACCESS cycle, no d_req.
  task automatic test_skip0();
    int total = 0, mem_cnt = 0, dreq_cnt = 0;
    bit done = 0;
    do_reset();
    set_op(0, 0, 1, 0, 0, 0);
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      i_ack = (stage_q1 == 3'd0);
      #1;
      total++;
      if (mem1) mem_cnt++;
      if (d_req1) dreq_cnt++;
      if (done1) done = 1;
    end
    i_ack = 0;
    checks++; if (!done) begin errors++; $display("FAIL skip0_timeout got no done_tick exp done_tick"); end
    checks++; if (total != 5) begin errors++; $display("FAIL skip0_total got %0d exp 5", total); end
    checks++; if (mem_cnt != 1) begin errors++; $display("FAIL skip0_mem_cycles got %0d exp 1", mem_cnt); end
    checks++; if (dreq_cnt != 0) begin errors++; $display("FAIL skip0_d_req got %0d exp 0", dreq_cnt); end
    @(negedge clk); #1;
    checks++; if (instret1 !== 64'd1) begin errors++; $display("FAIL skip0_instret got %0d exp 1", instret1); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw();
    test_jal_stall();
    test_flush();
    test_wrap_and_reset();
    test_skip0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
